sp_ram_be_clr: RTL

Parametrised single-port synchronous RAM. It is the next generation of the team's basic single-port RAM and adds:
- byte-lane write enables
- selectable read latency (1 or 2 cycles)
- selectable read-during-write mode
- a hardware clear engine that zeroes the whole array after reset or on request

It sits as the generic scratch/buffer memory in datapath blocks that need a known initial state and partial-word updates.

---
 rtl/sp_ram_be_clr_pkg.sv | 33 +++
 rtl/sp_ram_be_clr_core.sv | 63 ++++++
 rtl/sp_ram_be_clr.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/sp_ram_be_clr_pkg.sv
// ----------------------------------------------------------------------------
// sp_ram_be_clr_pkg
// Shared definitions for the byte-enable, self-clearing single-port RAM:
//   - clr_state_t       : clear engine FSM states (IDLE / CLEAR)
//   - WR_MODE_*         : encodings of the write-response selection
//   - bytes_of()        : number of byte lanes in a word
//   - rd_latency_legal(): legal read latencies (1 or 2)
// ----------------------------------------------------------------------------
package sp_ram_be_clr_pkg;

   // Clear engine states
   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } clr_state_t;

   // Write response selection
   localparam int WR_MODE_READ_FIRST  = 32'sd0;  // response carries the old word
   localparam int WR_MODE_WRITE_FIRST = 32'sd1;  // response carries the merged word

   localparam int BYTE_W = 32'sd8;

   // Number of byte lanes in a word of the given width
   function automatic int bytes_of(input int data_width);
      return data_width / BYTE_W;
   endfunction

   // Only 1- and 2-cycle read latencies are implemented
   function automatic bit rd_latency_legal(input int lat);
      return (lat == 32'sd1) || (lat == 32'sd2);
   endfunction

endpackage

// File: rtl/sp_ram_be_clr_core.sv
// ----------------------------------------------------------------------------
// sp_ram_core
// Plain single-port storage array with byte-lane write enables and a
// combinational read port. The word written is the merge of the current
// word and i_din under i_be, and that merged word is also exported so the
// caller can return it as a write-first response without recomputing it.
//
// Ports:
//   clk      in   clock (rising edge)
//   i_we     in   write strobe
//   i_addr   in   word address (shared by read and write)
//   i_din    in   write data
//   i_be     in   byte-lane enables, bit i covers i_din[8i+7:8i]
//   o_rdata  out  current word at i_addr (before any write on this edge)
//   o_merged out  word that a write at i_addr would store
// ----------------------------------------------------------------------------
module sp_ram_core
   import sp_ram_be_clr_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                      clk,
   input  logic                      i_we,
   input  logic [ADDR_WIDTH-1:0]     i_addr,
   input  logic [DATA_WIDTH-1:0]     i_din,
   input  logic [DATA_WIDTH/8-1:0]   i_be,
   output logic [DATA_WIDTH-1:0]     o_rdata,
   output logic [DATA_WIDTH-1:0]     o_merged
);

   localparam int NBYTES = bytes_of(DATA_WIDTH);
   localparam int DEPTH  = 32'sd1 << ADDR_WIDTH;

   // Storage is deliberately not reset; the clear engine defines contents.
   logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
   logic [DATA_WIDTH-1:0] w_rdata;
   logic [DATA_WIDTH-1:0] w_merged;

   assign w_rdata  = r_mem[i_addr];
   assign o_rdata  = w_rdata;
   assign o_merged = w_merged;

   // Byte-lane merge of write data into the currently stored word
   always_comb begin
      w_merged = w_rdata;
      for (int i = 0; i < NBYTES; i++) begin
         if (i_be[i]) begin
            w_merged[i*8 +: 8] = i_din[i*8 +: 8];
         end else begin
            w_merged[i*8 +: 8] = w_rdata[i*8 +: 8];
         end
      end
   end

   // Array write port
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= w_merged;
      end
   end

endmodule

// File: rtl/sp_ram_be_clr.sv
// ----------------------------------------------------------------------------
// sp_ram_be_clr
// Single-port synchronous RAM with byte-lane writes, 1- or 2-cycle read
// latency, read-first / write-first write responses and a clear engine that
// zeroes the array after reset (optional) or on a clr_req pulse.
//
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   en          in   access request, accepted only while busy=0
//   wr          in   1 = write, 0 = read
//   addr        in   word address
//   din         in   write data
//   be          in   byte-lane write enables
//   clr_req     in   start a full clear (ignored while clearing)
//   busy        out  clear engine active, accesses dropped
//   dout        out  response data, held between responses
//   dout_valid  out  one-cycle response strobe
// ----------------------------------------------------------------------------
module sp_ram_be_clr
   import sp_ram_be_clr_pkg::*;
#(
   parameter int DATA_WIDTH   = 16,
   parameter int ADDR_WIDTH   = 4,
   parameter int RD_LATENCY   = 1,
   parameter int WR_MODE      = 0,
   parameter int CLR_ON_RESET = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   input  logic                      wr,
   input  logic [ADDR_WIDTH-1:0]     addr,
   input  logic [DATA_WIDTH-1:0]     din,
   input  logic [DATA_WIDTH/8-1:0]   be,
   input  logic                      clr_req,
   output logic                      busy,
   output logic [DATA_WIDTH-1:0]     dout,
   output logic                      dout_valid
);

   localparam int NBYTES = bytes_of(DATA_WIDTH);
   localparam int DEPTH  = 32'sd1 << ADDR_WIDTH;
   // Unsupported latencies fall back to the single-cycle pipeline.
   localparam int LAT    = rd_latency_legal(RD_LATENCY) ? RD_LATENCY : 32'sd1;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 32'sd1);
   localparam logic                  RST_BUSY  = (CLR_ON_RESET != 32'sd0);

   clr_state_t              r_state;
   logic                    r_busy;
   logic [ADDR_WIDTH-1:0]   r_ptr;
   logic [DATA_WIDTH-1:0]   r_dout;
   logic                    r_dout_valid;

   logic                    w_accept;
   logic                    w_we;
   logic [ADDR_WIDTH-1:0]   w_addr;
   logic [DATA_WIDTH-1:0]   w_din;
   logic [NBYTES-1:0]       w_be;
   logic [DATA_WIDTH-1:0]   w_rdata;
   logic [DATA_WIDTH-1:0]   w_merged;
   logic [DATA_WIDTH-1:0]   w_resp;
   logic                    w_stage_v;
   logic [DATA_WIDTH-1:0]   w_stage_d;

   // A user access is only taken while the clear engine is idle.
   assign w_accept = en & ~r_busy;

   // Clear engine: walks r_ptr over every address, then returns to IDLE.
   // r_busy mirrors the CLEAR state so busy comes straight from a flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= RST_BUSY ? ST_CLEAR : ST_IDLE;
         r_busy  <= RST_BUSY;
         r_ptr   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (clr_req) begin
                  r_state <= ST_CLEAR;
                  r_busy  <= 1'b1;
               end
               r_ptr <= '0;
            end
            ST_CLEAR: begin
               if (r_ptr == LAST_ADDR) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_ptr   <= '0;
               end else begin
                  r_ptr   <= r_ptr + ADDR_WIDTH'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_ptr   <= '0;
            end
         endcase
      end
   end

   // Array port arbitration: the clear engine owns the port while busy.
   always_comb begin
      if (r_busy) begin
         w_we   = 1'b1;
         w_addr = r_ptr;
         w_din  = '0;
         w_be   = '1;
      end else begin
         w_we   = w_accept & wr;
         w_addr = addr;
         w_din  = din;
         w_be   = be;
      end
   end

   sp_ram_core #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_core (
      .clk      (clk),
      .i_we     (w_we),
      .i_addr   (w_addr),
      .i_din    (w_din),
      .i_be     (w_be),
      .o_rdata  (w_rdata),
      .o_merged (w_merged)
   );

   // Response word: reads and read-first writes return the pre-edge word.
   always_comb begin
      if (wr && (WR_MODE == WR_MODE_WRITE_FIRST)) begin
         w_resp = w_merged;
      end else begin
         w_resp = w_rdata;
      end
   end

   // Optional extra pipeline stage for the 2-cycle latency configuration.
   generate
      if (LAT == 32'sd2) begin : g_lat2
         logic                  r_v1;
         logic [DATA_WIDTH-1:0] r_d1;

         // First response stage, captured on the accepting edge
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_v1 <= 1'b0;
               r_d1 <= '0;
            end else begin
               r_v1 <= w_accept;
               if (w_accept) begin
                  r_d1 <= w_resp;
               end
            end
         end

         assign w_stage_v = r_v1;
         assign w_stage_d = r_d1;
      end else begin : g_lat1
         assign w_stage_v = w_accept;
         assign w_stage_d = w_resp;
      end
   endgenerate

   // Output register; dout only moves when a response is delivered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dout_valid <= 1'b0;
         r_dout       <= '0;
      end else begin
         r_dout_valid <= w_stage_v;
         if (w_stage_v) begin
            r_dout <= w_stage_d;
         end
      end
   end

   assign busy       = r_busy;
   assign dout       = r_dout;
   assign dout_valid = r_dout_valid;

endmodule
